// File: rtl/audio_stream_ctrl.sv
// Sample-transfer sequencer between the codec handshake and passthrough, ROM loop,
// ROM one-shot or mute sources; owns the ROM address and waits out the ROM read latency.
module audio_stream_ctrl #(
    parameter int ROM_DEPTH = 96000,
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 24,
    parameter int ROM_LAT   = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic [1:0]        mode,
    input  logic              read_ready,
    input  logic              write_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    input  logic [DATA_W-1:0] rom_q,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic              done,
    output logic              busy
);

    localparam int                CNT_W  = 2;
    localparam logic [1:0]        M_PASS = 2'b00;
    localparam logic [1:0]        M_LOOP = 2'b01;
    localparam logic [1:0]        M_ONE  = 2'b10;
    localparam logic [1:0]        M_MUTE = 2'b11;
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(ROM_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_END = CNT_W'(ROM_LAT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, XFER, GAP} state_t;

    state_t            state_q;
    logic [1:0]        mode_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [DATA_W-1:0] wd_l_q, wd_r_q;
    logic              done_q;

    logic              both_rdy;
    logic              mode_chg;
    logic              done_eff;
    logic              pulse;
    logic              rom_mode_q;
    logic [ADDR_W-1:0] rom_addr_d;
    logic              done_d;

    assign both_rdy   = read_ready && write_ready;
    assign mode_chg   = (mode != mode_q);
    // A mode change clears done in the same edge, so the new mode must not see the stale flag.
    assign done_eff   = done_q && !mode_chg;
    assign pulse      = (state_q == XFER) && both_rdy;
    assign rom_mode_q = (mode_q == M_LOOP) || (mode_q == M_ONE);

    // Address advance applied only on a pulse in a ROM mode.
    always_comb begin
        rom_addr_d = rom_addr_q;
        done_d     = done_q;
        if (rom_addr_q != LAST) begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
        end else if (mode_q == M_LOOP) begin
            rom_addr_d = '0;
        end else begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mode_q     <= M_PASS;
            cnt_q      <= '0;
            rom_addr_q <= '0;
            wd_l_q     <= '0;
            wd_r_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (both_rdy) begin
                        mode_q <= mode;
                        if (mode_chg) begin
                            rom_addr_q <= '0;
                            done_q     <= 1'b0;
                        end
                        cnt_q <= '0;
                        case (mode)
                            M_PASS: begin
                                wd_l_q  <= readdata_left;
                                wd_r_q  <= readdata_right;
                                state_q <= XFER;
                            end
                            M_MUTE: begin
                                wd_l_q  <= '0;
                                wd_r_q  <= '0;
                                state_q <= XFER;
                            end
                            M_ONE: begin
                                if (done_eff) begin
                                    wd_l_q  <= '0;
                                    wd_r_q  <= '0;
                                    state_q <= XFER;
                                end else begin
                                    state_q <= FETCH;
                                end
                            end
                            default: state_q <= FETCH;
                        endcase
                    end
                end
                FETCH: begin
                    // rom_addr is frozen here so rom_q settles on the address being played.
                    if (cnt_q == CNT_END) begin
                        wd_l_q  <= rom_q;
                        wd_r_q  <= rom_q;
                        state_q <= XFER;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                XFER: begin
                    if (pulse) begin
                        state_q <= GAP;
                        if (rom_mode_q) begin
                            rom_addr_q <= rom_addr_d;
                            done_q     <= done_d;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GAP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rom_addr        = rom_addr_q;
    assign read            = pulse;
    assign write           = pulse;
    assign writedata_left  = wd_l_q;
    assign writedata_right = wd_r_q;
    assign done            = done_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Directed bench for audio_stream_ctrl: a cycle-count transaction model checks every
// output each cycle, and directed literal checks pin the pulse values and timing.
module tb_audio_stream_ctrl;

    localparam int DEPTH  = 10;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 24;
    localparam int LAT    = 1;

    logic              CLOCK_50 = 1'b0;
    logic              reset_n;
    logic [1:0]        mode;
    logic              read_ready, write_ready;
    logic [DATA_W-1:0] readdata_left, readdata_right;
    logic [DATA_W-1:0] rom_q;
    logic [ADDR_W-1:0] rom_addr;
    logic              read, write, done, busy;
    logic [DATA_W-1:0] writedata_left, writedata_right;

    audio_stream_ctrl #(.ROM_DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(LAT)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .mode(mode),
        .read_ready(read_ready), .write_ready(write_ready),
        .readdata_left(readdata_left), .readdata_right(readdata_right),
        .rom_q(rom_q), .rom_addr(rom_addr), .read(read), .write(write),
        .writedata_left(writedata_left), .writedata_right(writedata_right),
        .done(done), .busy(busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // ROM content equals its address so played samples reveal the address sequence.
    assign rom_q = DATA_W'(rom_addr);

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    assert property (@(posedge CLOCK_50) disable iff (!reset_n)
        (read == write) && !(read && $past(read)));

    // Transaction model: a transfer starts when idle with both ready, the pulse slot is
    // 1 cycle later (plain source) or 1+LAT (ROM), followed by one dead cycle.
    bit          m_busy, m_rom, prev_rd;
    int          m_t, m_addr, slot;
    logic [1:0]  m_mode;
    bit          m_done;
    logic [DATA_W-1:0] m_wl, m_wr;
    bit          rdy, exp_rd;

    always @(negedge CLOCK_50) begin
        if (!reset_n) begin
            m_busy = 0; m_rom = 0; prev_rd = 0; m_t = 0; m_addr = 0;
            m_mode = 2'b00; m_done = 0; m_wl = '0; m_wr = '0;
        end else begin
            rdy    = read_ready && write_ready;
            slot   = m_rom ? 1 + LAT : 1;
            exp_rd = m_busy && (m_t == slot) && rdy;
            chk("read", 32'(read), 32'(exp_rd));
            chk("write", 32'(write), 32'(exp_rd));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("rom_addr", 32'(rom_addr), 32'(m_addr));
            chk("done", 32'(done), 32'(m_done));
            chk("wd_left", 32'(writedata_left), 32'(m_wl));
            chk("wd_right", 32'(writedata_right), 32'(m_wr));
            chk("no_back_to_back", 32'(read && prev_rd), 32'd0);
            prev_rd = read;
            if (!m_busy) begin
                if (rdy) begin
                    if (mode != m_mode) begin m_addr = 0; m_done = 0; end
                    m_mode = mode; m_busy = 1; m_t = 1; m_rom = 0;
                    if (mode == 2'b00) begin
                        m_wl = readdata_left; m_wr = readdata_right;
                    end else if (mode == 2'b11 || (mode == 2'b10 && m_done)) begin
                        m_wl = '0; m_wr = '0;
                    end else begin
                        m_rom = 1;
                    end
                end
            end else begin
                if (m_rom && m_t == LAT) begin m_wl = DATA_W'(m_addr); m_wr = DATA_W'(m_addr); end
                if (m_t == slot) begin
                    if (!exp_rd) m_busy = 0;
                    else if (m_mode == 2'b01 || m_mode == 2'b10) begin
                        if (m_addr < DEPTH - 1) m_addr++;
                        else if (m_mode == 2'b01) m_addr = 0;
                        else m_done = 1;
                    end
                end else if (m_t > slot) begin
                    m_busy = 0;
                end
                m_t++;
            end
        end
    end

    task automatic wait_pulse(output logic [DATA_W-1:0] l, output logic [DATA_W-1:0] r, output int at);
        bit got = 0;
        l = '0; r = '0; at = -1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge CLOCK_50);
            if (reset_n && read) begin
                got = 1; l = writedata_left; r = writedata_right; at = cyc;
            end
        end
        chk("pulse_seen", 32'(got), 32'd1);
    endtask

    task automatic step();
        @(posedge CLOCK_50); #1;
    endtask

    task automatic stop_ready();
        step(); read_ready = 0; write_ready = 0;
        repeat (3) step();
    endtask

    logic [DATA_W-1:0] l, r;
    int t0, at, at_prev;

    initial begin
        reset_n = 0; mode = 2'b00; read_ready = 0; write_ready = 0;
        readdata_left = '0; readdata_right = '0;
        #1;
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wd", 32'(writedata_left), 32'd0);
        repeat (2) step();
        reset_n = 1;
        repeat (2) step();

        // Passthrough: pulse one cycle after the start, then every 3 cycles.
        readdata_left = 24'h123456; readdata_right = 24'hABCDEF;
        read_ready = 1; write_ready = 1; t0 = cyc;
        wait_pulse(l, r, at);
        chk("pass_lat", 32'(at - t0), 32'd1);
        chk("pass_l", 32'(l), 32'h123456);
        chk("pass_r", 32'(r), 32'hABCDEF);
        at_prev = at;
        wait_pulse(l, r, at);
        chk("pass_spacing", 32'(at - at_prev), 32'd3);
        stop_ready();

        // ROM loop: samples 0..9 then wrap to 0, 1.
        mode = 2'b01; read_ready = 1; write_ready = 1; t0 = cyc;
        for (int i = 0; i < 12; i++) begin
            wait_pulse(l, r, at);
            if (i == 0) chk("loop_lat", 32'(at - t0), 32'(1 + LAT));
            if (i == 1) chk("loop_spacing", 32'(at - at_prev), 32'(3 + LAT));
            chk("loop_val", 32'(l), 32'(i % DEPTH));
            chk("loop_lr_eq", 32'(r), 32'(l));
            at_prev = at;
        end
        stop_ready();

        // One-shot: 0..9, then silence with address parked at the end and done set.
        mode = 2'b10; read_ready = 1; write_ready = 1;
        for (int i = 0; i < 12; i++) begin
            wait_pulse(l, r, at);
            chk("one_val", 32'(l), (i < DEPTH) ? 32'(i) : 32'd0);
        end
        chk("one_done", 32'(done), 32'd1);
        chk("one_addr_hold", 32'(rom_addr), 32'(DEPTH - 1));
        step(); mode = 2'b01;
        wait_pulse(l, r, at);
        chk("relooop_val", 32'(l), 32'd0);
        chk("reloop_done", 32'(done), 32'd0);
        stop_ready();

        // write_ready drops during FETCH: no pulse, address held, same sample later.
        read_ready = 1; write_ready = 1;
        step(); write_ready = 0;
        chk("drop_fetch_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLOCK_50);
            chk("drop_no_read", 32'(read), 32'd0);
        end
        chk("drop_addr", 32'(rom_addr), 32'd1);
        chk("drop_idle", 32'(busy), 32'd0);
        step(); write_ready = 1;
        wait_pulse(l, r, at);
        chk("drop_resend", 32'(l), 32'd1);
        stop_ready();

        // Mode change during GAP applies to the next sample only.
        mode = 2'b00; readdata_left = 24'h0F0F0F; readdata_right = 24'h707070;
        read_ready = 1; write_ready = 1;
        wait_pulse(l, r, at);
        chk("gap_pass_l", 32'(l), 32'h0F0F0F);
        chk("gap_pass_r", 32'(r), 32'h707070);
        at_prev = at;
        step(); mode = 2'b11;
        wait_pulse(l, r, at);
        chk("gap_mute_l", 32'(l), 32'd0);
        chk("gap_mute_r", 32'(r), 32'd0);
        chk("gap_spacing", 32'(at - at_prev), 32'd3);
        stop_ready();

        // Asynchronous reset in the middle of FETCH at address 5.
        mode = 2'b01; read_ready = 1; write_ready = 1;
        for (int i = 0; i < 5; i++) wait_pulse(l, r, at);
        repeat (3) step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_addr", 32'(rom_addr), 32'd5);
        #1 reset_n = 0;
        #1;
        chk("async_rst_addr", 32'(rom_addr), 32'd0);
        chk("async_rst_read", 32'(read), 32'd0);
        chk("async_rst_wd_l", 32'(writedata_left), 32'd0);
        chk("async_rst_wd_r", 32'(writedata_right), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        step(); read_ready = 0; write_ready = 0; reset_n = 1;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

endmodule
